// File: rtl/switch_led_axi_ctrl.sv
// AXI4-Lite switch/LED peripheral: debounced switches with sticky edge flags and
// a level interrupt, LEDs driven in passthrough, register, PWM or blink mode.
module switch_led_axi_ctrl #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_SW             = 8,
    parameter int NUM_LED            = 8,
    parameter int DEBOUNCE_CYCLES    = 1000,
    parameter int PWM_BITS           = 8
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic [NUM_SW-1:0]                 sw_in,
    output logic [NUM_LED-1:0]                led_out,
    output logic                              irq
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [1:0] MODE_PASS = 2'd0, MODE_REG = 2'd1, MODE_PWM = 2'd2, MODE_BLINK = 2'd3;

    genvar gi;

    logic [2:0]          ctrl_reg, ctrl_next;
    logic [NUM_LED-1:0]  led_data_reg, led_data_next;
    logic [PWM_BITS-1:0] duty_reg, duty_next, pwm_cnt_reg;
    logic [23:0]         div_reg, div_next, presc_reg;
    logic [NUM_SW-1:0]   irq_en_reg, irq_en_next;
    logic [NUM_SW-1:0]   sw_edge_reg, sw_edge_next, edge_clr;
    logic [NUM_SW-1:0]   sync1_reg, sync2_reg, deb_reg, deb_next, deb_d_reg;
    logic                phase_reg, div_wr;
    logic                awready_reg, bvalid_reg, arready_reg, rvalid_reg, irq_reg;
    logic [31:0]         rdata_reg;
    logic [NUM_LED-1:0]  led_reg, led_sel;

    logic        wr_fire, rd_fire;
    logic [2:0]  wr_idx, rd_idx;
    logic [31:0] wmask, wr_word, sw_ext;
    logic [31:0] regs_view [8];

    assign wr_fire = awready_reg & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_fire = arready_reg & S_AXI_ARVALID;
    assign wr_idx  = S_AXI_AWADDR[4:2];
    assign rd_idx  = S_AXI_ARADDR[4:2];
    assign sw_ext  = 32'(deb_reg);

    for (gi = 0; gi < 4; gi++) begin : g_strb
        assign wmask[8*gi +: 8] = {8{S_AXI_WSTRB[gi]}};
    end

    assign regs_view[0] = {29'd0, ctrl_reg};
    assign regs_view[1] = 32'(led_data_reg);
    assign regs_view[2] = 32'(deb_reg);
    assign regs_view[3] = 32'(sw_edge_reg);
    assign regs_view[4] = 32'(duty_reg);
    assign regs_view[5] = {8'd0, div_reg};
    assign regs_view[6] = 32'(irq_en_reg);
    assign regs_view[7] = 32'h5710_0200;

    assign wr_word = (regs_view[wr_idx] & ~wmask) | (S_AXI_WDATA[31:0] & wmask);

    // Per-switch debounce: count consecutive cycles where the synchronised pin disagrees.
    for (gi = 0; gi < NUM_SW; gi++) begin : g_db
        logic [CNT_W-1:0] cnt_reg;
        logic             differ, hit;
        assign differ       = sync2_reg[gi] != deb_reg[gi];
        assign hit          = differ && (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1));
        assign deb_next[gi] = hit ? sync2_reg[gi] : deb_reg[gi];
        always_ff @(posedge S_AXI_ACLK) begin
            if (S_AXI_ARESET || !differ || hit)
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    always_comb begin
        ctrl_next     = ctrl_reg;
        led_data_next = led_data_reg;
        duty_next     = duty_reg;
        div_next      = div_reg;
        irq_en_next   = irq_en_reg;
        edge_clr      = '0;
        div_wr        = 1'b0;
        if (wr_fire) begin
            case (wr_idx)
                3'd0: ctrl_next     = wr_word[2:0];
                3'd1: led_data_next = wr_word[NUM_LED-1:0];
                3'd3: edge_clr      = S_AXI_WDATA[NUM_SW-1:0] & wmask[NUM_SW-1:0];
                3'd4: duty_next     = wr_word[PWM_BITS-1:0];
                3'd5: begin
                    div_next = wr_word[23:0];
                    div_wr   = 1'b1;
                end
                3'd6: irq_en_next   = wr_word[NUM_SW-1:0];
                default: ;
            endcase
        end
        // A new transition outranks a simultaneous W1C.
        sw_edge_next = (sw_edge_reg & ~edge_clr) | (deb_reg ^ deb_d_reg);
    end

    always_comb begin
        led_sel = '0;
        case (ctrl_reg[2:1])
            MODE_PASS:  led_sel = sw_ext[NUM_LED-1:0];
            MODE_REG:   led_sel = led_data_reg;
            MODE_PWM:   led_sel = (pwm_cnt_reg < duty_reg) ? led_data_reg : '0;
            MODE_BLINK: led_sel = phase_reg ? led_data_reg : '0;
            default:    led_sel = '0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            ctrl_reg     <= '0;
            led_data_reg <= '0;
            duty_reg     <= '0;
            div_reg      <= '0;
            irq_en_reg   <= '0;
            sw_edge_reg  <= '0;
            sync1_reg    <= '0;
            sync2_reg    <= '0;
            deb_reg      <= '0;
            deb_d_reg    <= '0;
            pwm_cnt_reg  <= '0;
            presc_reg    <= '0;
            phase_reg    <= 1'b0;
            awready_reg  <= 1'b0;
            bvalid_reg   <= 1'b0;
            arready_reg  <= 1'b0;
            rvalid_reg   <= 1'b0;
            rdata_reg    <= '0;
            irq_reg      <= 1'b0;
            led_reg      <= '0;
        end else begin
            ctrl_reg     <= ctrl_next;
            led_data_reg <= led_data_next;
            duty_reg     <= duty_next;
            div_reg      <= div_next;
            irq_en_reg   <= irq_en_next;
            sw_edge_reg  <= sw_edge_next;
            sync1_reg    <= sw_in;
            sync2_reg    <= sync1_reg;
            deb_reg      <= deb_next;
            deb_d_reg    <= deb_reg;
            irq_reg      <= |(sw_edge_next & irq_en_next);
            led_reg      <= ctrl_reg[0] ? led_sel : '0;
            pwm_cnt_reg  <= pwm_cnt_reg + 1'b1;

            if (div_wr) begin
                presc_reg <= '0;
                phase_reg <= 1'b0;
            end else if (presc_reg == div_reg) begin
                presc_reg <= '0;
                phase_reg <= ~phase_reg;
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end

            // Address and data are accepted together, one transaction in flight at a time.
            awready_reg <= !awready_reg && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_reg;
            if (wr_fire)
                bvalid_reg <= 1'b1;
            else if (S_AXI_BREADY)
                bvalid_reg <= 1'b0;

            arready_reg <= !arready_reg && S_AXI_ARVALID && !rvalid_reg;
            if (rd_fire) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= regs_view[rd_idx];
            end else if (S_AXI_RREADY) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = awready_reg;
    assign S_AXI_WREADY  = awready_reg;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_ARREADY = arready_reg;
    assign S_AXI_RDATA   = C_S_AXI_DATA_WIDTH'(rdata_reg);
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_reg;
    assign led_out       = led_reg;
    assign irq           = irq_reg;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                           S_AXI_WDATA, wr_word, wmask, sw_ext};
endmodule

// File: tb/tb_switch_led_axi_ctrl.sv
// Directed bench for switch_led_axi_ctrl with a short debounce window.
module tb_switch_led_axi_ctrl;
    logic        clk = 1'b0;
    logic        srst;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [7:0]  sw_in, led_out;
    logic        irq;

    int err_count = 0;
    int chk_count = 0;

    always #5 clk = ~clk;

    switch_led_axi_ctrl #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .NUM_SW(8), .NUM_LED(8),
        .DEBOUNCE_CYCLES(4), .PWM_BITS(8)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(srst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .sw_in(sw_in), .led_out(led_out), .irq(irq)
    );

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (awready !== 1'b1) begin
            chk_count++; err_count++;
            $display("FAIL write_accept addr=%h awready=%b required 1", addr, awready);
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (bvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (bvalid !== 1'b1) begin
            chk_count++; err_count++;
            $display("FAIL write_resp addr=%h bvalid=%b required 1", addr, bvalid);
        end
        @(posedge clk); #1;
        bready = 1'b0;
        $display("write addr=%h data=%h strb=%h", addr, data, strb);
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
        int n;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (arready !== 1'b1) begin
            chk_count++; err_count++;
            $display("FAIL read_accept addr=%h arready=%b required 1", addr, arready);
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (rvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (rvalid !== 1'b1) begin
            chk_count++; err_count++;
            $display("FAIL read_resp addr=%h rvalid=%b required 1", addr, rvalid);
        end
        data = rdata;
        @(posedge clk); #1;
        rready = 1'b0;
        $display("read  addr=%h data=%h", addr, data);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] exp_tab [8];
        exp_tab = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h5710_0200};
        srst = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_count++;
        if ({led_out, irq, awready, wready, arready, bvalid, rvalid} !== 14'd0 || rdata !== 32'd0) begin
            err_count++;
            $display("FAIL reset_outputs led=%h irq=%b awr=%b ar=%b bv=%b rv=%b rdata=%h required all 0",
                     led_out, irq, awready, arready, bvalid, rvalid, rdata);
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(posedge clk); #1;
        srst = 1'b0;
        repeat (2) @(negedge clk);
        chk_count++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
            err_count++;
            $display("FAIL reset_abandon bvalid=%b rvalid=%b required 0 0", bvalid, rvalid);
        end
        for (int i = 0; i < 8; i++) begin
            axi_read(5'(i * 4), d);
            chk_count++;
            if (d !== exp_tab[i]) begin
                err_count++;
                $display("FAIL reset_read off=%0h got=%h required %h", i * 4, d, exp_tab[i]);
            end
        end
    endtask

    task automatic test_debounce();
        logic [31:0] d;
        axi_write(5'h18, 32'h05, 4'hF);
        @(posedge clk); #1;
        sw_in = 8'h05;
        repeat (6) @(posedge clk); #1;
        chk_count++;
        if (irq !== 1'b0) begin
            err_count++;
            $display("FAIL debounce_early irq=%b required 0", irq);
        end
        @(posedge clk); #1;
        chk_count++;
        if (irq !== 1'b1) begin
            err_count++;
            $display("FAIL debounce_latency irq=%b required 1", irq);
        end
        axi_read(5'h08, d);
        chk_count++;
        if (d !== 32'h05) begin err_count++; $display("FAIL sw_status got=%h required 05", d); end
        axi_read(5'h0C, d);
        chk_count++;
        if (d !== 32'h05) begin err_count++; $display("FAIL sw_edge got=%h required 05", d); end
        @(posedge clk); #1;
        sw_in = 8'h85;
        repeat (3) @(posedge clk); #1;
        sw_in = 8'h05;
        repeat (12) @(posedge clk);
        axi_read(5'h08, d);
        chk_count++;
        if (d !== 32'h05) begin err_count++; $display("FAIL glitch_status got=%h required 05", d); end
        axi_read(5'h0C, d);
        chk_count++;
        if (d !== 32'h05) begin err_count++; $display("FAIL glitch_edge got=%h required 05", d); end
        axi_write(5'h0C, 32'hFF, 4'hF);
        axi_read(5'h0C, d);
        chk_count++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            err_count++;
            $display("FAIL edge_clear edge=%h irq=%b required 0 0", d, irq);
        end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        int n;
        axi_write(5'h18, 32'h01, 4'hF);
        @(posedge clk); #1;
        sw_in = 8'h04;
        repeat (10) @(posedge clk); #1;
        chk_count++;
        if (irq !== 1'b1) begin err_count++; $display("FAIL irq_set irq=%b required 1", irq); end
        axi_write(5'h0C, 32'h01, 4'hF);
        chk_count++;
        if (irq !== 1'b0) begin err_count++; $display("FAIL irq_clear irq=%b required 0", irq); end
        // Line the W1C handshake up with the edge that sets the flag again.
        @(posedge clk); #1;
        sw_in = 8'h05;
        repeat (5) @(posedge clk); #1;
        awaddr = 5'h0C; wdata = 32'h01; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_count++;
        if (awready !== 1'b1) begin err_count++; $display("FAIL collide_align awready=%b required 1", awready); end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (bvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bready = 1'b0;
        chk_count++;
        if (irq !== 1'b1) begin err_count++; $display("FAIL collide_irq irq=%b required 1", irq); end
        axi_read(5'h0C, d);
        chk_count++;
        if (d !== 32'h01) begin err_count++; $display("FAIL collide_edge got=%h required 01", d); end
        axi_write(5'h0C, 32'hFF, 4'hF);
        axi_write(5'h18, 32'h00, 4'hF);
    endtask

    task automatic test_led_register();
        logic [31:0] d;
        axi_write(5'h00, 32'h03, 4'hF);
        axi_write(5'h04, 32'h1234_56A5, 4'h1);
        repeat (2) @(posedge clk); #1;
        chk_count++;
        if (led_out !== 8'hA5) begin err_count++; $display("FAIL led_reg got=%h required a5", led_out); end
        axi_read(5'h04, d);
        chk_count++;
        if (d !== 32'hA5) begin err_count++; $display("FAIL led_data_read got=%h required a5", d); end
        axi_write(5'h00, 32'h01, 4'hF);
        repeat (2) @(posedge clk); #1;
        chk_count++;
        if (led_out !== 8'h05) begin err_count++; $display("FAIL led_pass got=%h required 05", led_out); end
        axi_write(5'h00, 32'h02, 4'hF);
        repeat (2) @(posedge clk); #1;
        chk_count++;
        if (led_out !== 8'h00) begin err_count++; $display("FAIL led_disabled got=%h required 00", led_out); end
    endtask

    task automatic test_pwm();
        int on_cnt, bad;
        axi_write(5'h00, 32'h05, 4'hF);
        axi_write(5'h04, 32'hFF, 4'hF);
        axi_write(5'h10, 32'd64, 4'hF);
        on_cnt = 0; bad = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (led_out === 8'hFF) on_cnt++;
            else if (led_out !== 8'h00) bad++;
        end
        chk_count++;
        if (on_cnt != 64 || bad != 0) begin
            err_count++;
            $display("FAIL pwm_64 on=%0d other=%0d required on=64 other=0", on_cnt, bad);
        end
        axi_write(5'h10, 32'd0, 4'hF);
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (led_out !== 8'h00) on_cnt++;
        end
        chk_count++;
        if (on_cnt != 0) begin err_count++; $display("FAIL pwm_0 on=%0d required 0", on_cnt); end
    endtask

    task automatic test_blink();
        logic [7:0] prev, v, exp_v;
        int n, bad;
        axi_write(5'h04, 32'h0F, 4'hF);
        axi_write(5'h00, 32'h07, 4'hF);
        axi_write(5'h14, 32'd9, 4'hF);
        @(negedge clk);
        prev = led_out;
        n = 0;
        do begin @(negedge clk); n++; end while (led_out === prev && n < 30);
        v = led_out;
        chk_count++;
        if (n >= 30 || (v !== 8'h0F && v !== 8'h00)) begin
            err_count++;
            $display("FAIL blink_toggle led=%h waited=%0d required toggle to 0f/00", v, n);
        end
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            exp_v = (((k / 10) % 2) == 0) ? v : (v ^ 8'h0F);
            if (led_out !== exp_v) bad++;
            @(negedge clk);
        end
        chk_count++;
        if (bad != 0) begin err_count++; $display("FAIL blink_period bad_samples=%0d required 0", bad); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int n, bad;
        @(negedge clk);
        awaddr = 5'h10; wdata = 32'h33; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        while (awready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        wdata = 32'h44;
        n = 0;
        while (bvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bvalid !== 1'b1 || awready !== 1'b0 || bresp !== 2'b00) bad++;
            if (i < 4) @(negedge clk);
        end
        chk_count++;
        if (bad != 0) begin err_count++; $display("FAIL b_stall bad_cycles=%0d required 0", bad); end
        bready = 1'b1; awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        bready = 1'b0;
        axi_read(5'h10, d);
        chk_count++;
        if (d !== 32'h33) begin err_count++; $display("FAIL no_second_write duty=%h required 33", d); end

        @(negedge clk);
        araddr = 5'h1C; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        while (arready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        araddr = 5'h00;
        n = 0;
        while (rvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (rvalid !== 1'b1 || arready !== 1'b0 || rdata !== 32'h5710_0200 || rresp !== 2'b00) bad++;
            if (i < 4) @(negedge clk);
        end
        chk_count++;
        if (bad != 0) begin err_count++; $display("FAIL r_stall bad_cycles=%0d rdata=%h required 0 57100200", bad, rdata); end
        rready = 1'b1; arvalid = 1'b0;
        @(posedge clk); #1;
        rready = 1'b0;
        @(negedge clk);
        chk_count++;
        if (rvalid !== 1'b0) begin err_count++; $display("FAIL r_release rvalid=%b required 0", rvalid); end
    endtask

    initial begin
        srst = 1'b1; sw_in = '0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        test_reset();
        test_debounce();
        test_irq();
        test_led_register();
        test_pwm();
        test_blink();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", err_count, chk_count);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end
endmodule
